ps2_key_sequencer: RTL and testbench
====================================

# ps2_key_sequencer

Sequences raw PS/2 set-2 scan-code bytes from the keyboard receiver into ASCII key events for the text-overlay writer. Tracks the 0xE0 (extended) and 0xF0 (break) prefix protocol, Shift/Caps Lock modifier state and auto-repeat, and translates make codes to characters. Buffers translated characters in a small first-word-fall-through FIFO drained by the character-write logic through a valid/ready handshake.

## Interface
- FIFO_DEPTH, 8, character FIFO entries; power of two, 2..64
- clk  in  1  system clock, same domain as receiver
- reset  in  1  synchronous, active-low
- scan_data  in  8  scan byte from receiver; sampled only when scan_data_valid detected
- scan_data_valid  in  1  byte strobe; rising edge = one byte (level held N cycles counts once)
- key_ascii  out  8  FIFO head character; 0x00 when empty
- key_valid  out  1  FIFO not empty
- key_ready  in  1  consumer accepts head when key_valid & key_ready
- shift_held  out  1  either Shift key currently down
- caps_lock  out  1  Caps Lock toggle state
- overflow  out  1  sticky: a translated character was dropped because FIFO full

## Operation
- Byte detect: register scan_data_valid; strobe = valid & ~valid_d. Non-strobe cycles change nothing in the decoder.
- Decoder FSM states: IDLE, BRK (0xF0 seen), EXT (0xE0 seen), EXT_BRK (0xE0 0xF0 seen).
  - IDLE: 0xE0->EXT; 0xF0->BRK; other byte = make code, process, stay IDLE.
  - EXT: 0xF0->EXT_BRK; 0xE0 stays EXT; other = extended make, process, ->IDLE.
  - BRK: any byte = break code, process, ->IDLE. EXT_BRK: any byte = extended break, ->IDLE.
- Modifiers: make 0x12/0x59 sets lshift/rshift; break clears; shift_held = lshift|rshift. Make 0x58 toggles caps_lock only if caps_down=0, then sets caps_down; break 0x58 clears caps_down (auto-repeat does not re-toggle).
- Translation (normal make only; modifiers produce no character):
  - letters 0x1C a, 0x32 b, 0x21 c, 0x23 d, 0x24 e ... full set-2 alphabet; lowercase 0x61-0x7A; uppercase when shift_held XOR caps_lock.
  - digits 0x16 '1' ... 0x45 '0'; with shift_held: "!@#$%^&*()" (caps_lock ignored).
  - 0x29 space 0x20, 0x5A Enter 0x0D, 0x66 Backspace 0x08, 0x0D Tab 0x09, 0x76 Esc 0x1B.
  - extended make: 0x75 up 0x11, 0x72 down 0x12, 0x6B left 0x13, 0x74 right 0x14; other extended codes dropped.
  - unmapped codes and all break codes produce nothing; repeated make codes each produce a character.
- Modifier state used for translation is the value before the current byte.
- FIFO: push when translation hit and (not full or pop this cycle); else overflow<=1 and drop. Pop on key_valid & key_ready. Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

## Timing
- Reset (reset=0 at clk edge): FSM IDLE, shift/caps/caps_down 0, FIFO empty, overflow 0, key_valid 0, key_ascii 0x00, valid_d 0.
- Strobe detected at edge E (valid high, valid_d low); FSM/modifier update and translated char registered at edge E+1; FIFO write at edge E+2; key_valid high after edge E+2.
- key_ascii/key_valid are registered/FIFO-head outputs, stable for whole cycle; head advances the edge after a pop.
- Simultaneous push and pop when full: both occur, count unchanged. Push and pop when empty: push only (pop ignored, key_valid was 0).
- Reset asserted mid-prefix or mid-FIFO: all state discarded at that edge; next byte decoded from IDLE.
- overflow only clears on reset.

## Test plan
- Reset then bytes 0x1C, 0xF0, 0x1C -> exactly one entry 0x61; key_valid high 2 cycles after first strobe; break produces nothing.
- 0x12, 0x1C, 0x16, 0xF0, 0x12, 0x1C -> FIFO "A", "!", "a"; shift_held 1 then 0.
- 0x58, 0x58(repeat), 0xF0, 0x58, 0x12, 0x1C -> caps_lock 1 (single toggle), character 0x61 (shift XOR caps).
- 0xE0, 0x75, 0xE0, 0xF0, 0x75, 0xE0, 0x12 -> one entry 0x11; FSM back to IDLE; shift_held stays 0.
- key_ready=0, send 9 x 0x29 with FIFO_DEPTH=8 -> 8 entries 0x20, overflow=1; then key_ready=1 with simultaneous new push -> all drained in order, no further drop.
- scan_data_valid held high 5 cycles with 0x1C -> one character only; reset asserted after 0xF0 -> next 0x1C yields 0x61.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// PS/2 set-2 scan-code sequencer: prefix decoding, Shift/Caps Lock tracking,
// ASCII translation and a first-word-fall-through character FIFO.
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_data,
  input  logic       scan_data_valid,
  output logic [7:0] key_ascii,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       shift_held,
  output logic       caps_lock,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t state, state_next;

  logic       valid_d, byte_stb;
  logic [7:0] byte_r;
  logic       lshift, rshift, caps_down;
  logic       make_normal, break_normal, make_ext;
  logic [8:0] xlate;
  logic       char_hit;
  logic [7:0] char_r;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, push, pop;

  // Returns {hit, ascii} for a normal (non-extended) make code.
  function automatic logic [8:0] xlate_normal(input logic [7:0] code,
                                              input logic shift,
                                              input logic caps);
    logic [7:0] lower, plain, shifted;
    logic [8:0] result;
    lower = 8'h00; plain = 8'h00; shifted = 8'h00; result = 9'h000;
    case (code)
      8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";
      8'h23: lower = "d";  8'h24: lower = "e";  8'h2B: lower = "f";
      8'h34: lower = "g";  8'h33: lower = "h";  8'h43: lower = "i";
      8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
      8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";
      8'h4D: lower = "p";  8'h15: lower = "q";  8'h2D: lower = "r";
      8'h1B: lower = "s";  8'h2C: lower = "t";  8'h3C: lower = "u";
      8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
      8'h35: lower = "y";  8'h1A: lower = "z";
      default: lower = 8'h00;
    endcase
    case (code)
      8'h16: begin plain = "1"; shifted = "!"; end
      8'h1E: begin plain = "2"; shifted = "@"; end
      8'h26: begin plain = "3"; shifted = "#"; end
      8'h25: begin plain = "4"; shifted = "$"; end
      8'h2E: begin plain = "5"; shifted = "%"; end
      8'h36: begin plain = "6"; shifted = "^"; end
      8'h3D: begin plain = "7"; shifted = "&"; end
      8'h3E: begin plain = "8"; shifted = "*"; end
      8'h46: begin plain = "9"; shifted = "("; end
      8'h45: begin plain = "0"; shifted = ")"; end
      default: begin plain = 8'h00; shifted = 8'h00; end
    endcase
    if (lower != 8'h00)
      result = {1'b1, (shift ^ caps) ? (lower - 8'h20) : lower};
    else if (plain != 8'h00)
      result = {1'b1, shift ? shifted : plain};
    else begin
      case (code)
        8'h29:   result = {1'b1, 8'h20};
        8'h5A:   result = {1'b1, 8'h0D};
        8'h66:   result = {1'b1, 8'h08};
        8'h0D:   result = {1'b1, 8'h09};
        8'h76:   result = {1'b1, 8'h1B};
        default: result = 9'h000;
      endcase
    end
    return result;
  endfunction

  function automatic logic [8:0] xlate_ext(input logic [7:0] code);
    logic [8:0] result;
    case (code)
      8'h75:   result = {1'b1, 8'h11};
      8'h72:   result = {1'b1, 8'h12};
      8'h6B:   result = {1'b1, 8'h13};
      8'h74:   result = {1'b1, 8'h14};
      default: result = 9'h000;
    endcase
    return result;
  endfunction

  // Rising-edge byte detect: a level held for many cycles is one byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_d  <= 1'b0;
      byte_stb <= 1'b0;
      byte_r   <= 8'h00;
    end else begin
      valid_d  <= scan_data_valid;
      byte_stb <= scan_data_valid & ~valid_d;
      byte_r   <= scan_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    make_normal  = 1'b0;
    break_normal = 1'b0;
    make_ext     = 1'b0;
    if (byte_stb) begin
      case (state)
        IDLE: begin
          if (byte_r == 8'hE0)      state_next = EXT;
          else if (byte_r == 8'hF0) state_next = BRK;
          else                      make_normal = 1'b1;
        end
        EXT: begin
          if (byte_r == 8'hF0)      state_next = EXT_BRK;
          else if (byte_r == 8'hE0) state_next = EXT;
          else begin
            make_ext   = 1'b1;
            state_next = IDLE;
          end
        end
        BRK: begin
          break_normal = 1'b1;
          state_next   = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
    if (make_normal)   xlate = xlate_normal(byte_r, shift_held, caps_lock);
    else if (make_ext) xlate = xlate_ext(byte_r);
    else               xlate = 9'h000;
  end

  assign shift_held = lshift | rshift;

  // Translation reads the modifier values from before this byte's update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_lock <= 1'b0;
      caps_down <= 1'b0;
      char_hit  <= 1'b0;
      char_r    <= 8'h00;
    end else begin
      char_hit <= xlate[8];
      char_r   <= xlate[7:0];
      if (make_normal) begin
        case (byte_r)
          8'h12: lshift <= 1'b1;
          8'h59: rshift <= 1'b1;
          8'h58: begin
            if (!caps_down) caps_lock <= ~caps_lock;
            caps_down <= 1'b1;
          end
          default: ;
        endcase
      end
      if (break_normal) begin
        case (byte_r)
          8'h12:   lshift    <= 1'b0;
          8'h59:   rshift    <= 1'b0;
          8'h58:   caps_down <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign full      = (count == CNT_FULL);
  assign key_valid = (count != '0);
  assign key_ascii = key_valid ? mem[rd_ptr] : 8'h00;
  assign pop       = key_valid & key_ready;
  assign push      = char_hit & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= char_r;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (char_hit && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench: scan bytes in, expected characters queued at drive time and
// compared in order as the consumer accepts them.
module tb_ps2_key_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] scan_data;
  logic       scan_data_valid;
  logic [7:0] key_ascii;
  logic       key_valid;
  logic       key_ready;
  logic       shift_held;
  logic       caps_lock;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  ps2_key_sequencer #(.FIFO_DEPTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .scan_data       (scan_data),
    .scan_data_valid (scan_data_valid),
    .key_ascii       (key_ascii),
    .key_valid       (key_valid),
    .key_ready       (key_ready),
    .shift_held      (shift_held),
    .caps_lock       (caps_lock),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One byte: strobe for one cycle, return at the negedge after E+1.
  task automatic applyStimulus(input logic [7:0] b);
    scan_data       = b;
    scan_data_valid = 1'b1;
    @(negedge clk);
    scan_data_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic doReset();
    reset           = 1'b0;
    scan_data_valid = 1'b0;
    settle(2);
    reset = 1'b1;
    exp_q.delete();
    checkOutput("rst_key_valid", 32'(key_valid), 32'd0);
    checkOutput("rst_key_ascii", 32'(key_ascii), 32'd0);
    checkOutput("rst_shift", 32'(shift_held), 32'd0);
    checkOutput("rst_caps", 32'(caps_lock), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
  endtask

  // Consumer side: every accepted head must match the oldest expected entry.
  always begin
    @(negedge clk);
    #1;
    if (reset && key_valid && key_ready) begin
      if (exp_q.size() == 0)
        checkOutput("unexpected_char", 32'(key_ascii), 32'h100);
      else
        checkOutput("head_char", 32'(key_ascii), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset           = 1'b0;
    scan_data       = 8'h00;
    scan_data_valid = 1'b0;
    key_ready       = 1'b1;
    settle(3);
    doReset();

    $display("[TB] make/break of 'a' with pipeline latency");
    exp_q.push_back(8'h61);
    applyStimulus(8'h1C);
    checkOutput("t1_valid_before_E2", 32'(key_valid), 32'd0);
    @(negedge clk);
    checkOutput("t1_valid_after_E2", 32'(key_valid), 32'd1);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    settle(4);
    checkOutput("t1_one_entry", 32'(exp_q.size()), 32'd0);
    checkOutput("t1_empty_after", 32'(key_valid), 32'd0);

    $display("[TB] shift letters and digits");
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h61);
    applyStimulus(8'h12);
    checkOutput("t2_shift_down", 32'(shift_held), 32'd1);
    applyStimulus(8'h1C);
    applyStimulus(8'h16);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    checkOutput("t2_shift_up", 32'(shift_held), 32'd0);
    applyStimulus(8'h1C);
    waitDrain("t2_drain");

    $display("[TB] caps lock with auto-repeat and shift");
    exp_q.push_back(8'h61);
    applyStimulus(8'h58);
    checkOutput("t3_caps_on", 32'(caps_lock), 32'd1);
    applyStimulus(8'h58);
    checkOutput("t3_caps_repeat", 32'(caps_lock), 32'd1);
    applyStimulus(8'hF0);
    applyStimulus(8'h58);
    checkOutput("t3_caps_release", 32'(caps_lock), 32'd1);
    applyStimulus(8'h12);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    waitDrain("t3_drain");

    $display("[TB] extended codes");
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h41);
    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    applyStimulus(8'hE0);
    applyStimulus(8'h12);
    checkOutput("t4_ext_shift", 32'(shift_held), 32'd0);
    applyStimulus(8'h1C);
    waitDrain("t4_drain");
    checkOutput("t4_caps_kept", 32'(caps_lock), 32'd1);
    doReset();

    $display("[TB] fill to overflow, then push while full and draining");
    key_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h20);
      applyStimulus(8'h29);
    end
    settle(2);
    checkOutput("t5_full_no_ovf", 32'(overflow), 32'd0);
    applyStimulus(8'h29);
    settle(2);
    checkOutput("t5_overflow", 32'(overflow), 32'd1);
    checkOutput("t5_head", 32'(key_ascii), 32'h20);
    exp_q.push_back(8'h61);
    applyStimulus(8'h1C);
    key_ready = 1'b1;
    waitDrain("t5_drain");
    settle(1);
    checkOutput("t5_empty", 32'(key_valid), 32'd0);
    checkOutput("t5_ovf_sticky", 32'(overflow), 32'd1);

    $display("[TB] reset with FIFO occupied");
    key_ready = 1'b0;
    applyStimulus(8'h1C);
    applyStimulus(8'h1C);
    settle(2);
    checkOutput("t6_pending", 32'(key_valid), 32'd1);
    doReset();
    key_ready = 1'b1;

    $display("[TB] held strobe and reset mid-prefix");
    exp_q.push_back(8'h61);
    scan_data       = 8'h1C;
    scan_data_valid = 1'b1;
    settle(5);
    scan_data_valid = 1'b0;
    waitDrain("t7_held_drain");
    settle(4);
    checkOutput("t7_held_single", 32'(key_valid), 32'd0);
    applyStimulus(8'hF0);
    doReset();
    exp_q.push_back(8'h61);
    applyStimulus(8'h1C);
    waitDrain("t7_after_reset");

    settle(4);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
